// File: rtl/sub_shift_iter.sv
// Iterative AES SubBytes + ShiftRows: one output column per cycle through 4 shared S-boxes.
// Optional inverse transform (InvSubBytes + InvShiftRows) enabled by defining SUB_SHIFT_INV_EN.

module sub_shift_sbox (
  input  logic [7:0] x,
  output logic [7:0] y
);
  localparam logic [0:2047] TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = TABLE[{x, 3'b000} +: 8];
endmodule

`ifdef SUB_SHIFT_INV_EN
module sub_shift_inv_sbox (
  input  logic [7:0] x,
  output logic [7:0] y
);
  localparam logic [0:2047] TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign y = TABLE[{x, 3'b000} +: 8];
endmodule
`endif

module sub_shift_iter (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] data_in,
  output logic         out_valid,
  input  logic         out_ready,
`ifdef SUB_SHIFT_INV_EN
  input  logic         inv,
`endif
  output logic [0:127] data_out
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       state;
  logic [1:0]   col;
  logic [0:127] src;
`ifdef SUB_SHIFT_INV_EN
  logic         inv_q;
`endif

  logic [7:0] fwd_in  [4];
  logic [7:0] fwd_out [4];
  logic [7:0] sub_out [4];
  logic [0:31] col_word;

  // Byte (row r, column c) lives at bit offset 8*(4c+r); the row shift is folded into the column index.
  for (genvar r = 0; r < 4; r++) begin : g_row
    logic [1:0] fcol;
    assign fcol      = col + 2'(r);
    assign fwd_in[r] = src[{fcol, 2'(r), 3'b000} +: 8];

    sub_shift_sbox u_sbox (
      .x(fwd_in[r]),
      .y(fwd_out[r])
    );

`ifdef SUB_SHIFT_INV_EN
    logic [1:0] icol;
    logic [7:0] inv_in;
    logic [7:0] inv_out;
    assign icol   = col - 2'(r);
    assign inv_in = src[{icol, 2'(r), 3'b000} +: 8];

    sub_shift_inv_sbox u_inv_sbox (
      .x(inv_in),
      .y(inv_out)
    );

    assign sub_out[r] = inv_q ? inv_out : fwd_out[r];
`else
    assign sub_out[r] = fwd_out[r];
`endif
  end

  assign col_word = {sub_out[0], sub_out[1], sub_out[2], sub_out[3]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      col       <= 2'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      src       <= '0;
      data_out  <= '0;
`ifdef SUB_SHIFT_INV_EN
      inv_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            src      <= data_in;
            col      <= 2'd0;
            in_ready <= 1'b0;
            state    <= BUSY;
`ifdef SUB_SHIFT_INV_EN
            inv_q    <= inv;
`endif
          end
        end
        BUSY: begin
          data_out[{col, 5'b00000} +: 32] <= col_word;
          col <= col + 2'd1;
          if (col == 2'd3) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sub_shift_iter.md
# sub_shift_iter

Iterative AES SubBytes + ShiftRows stage placed directly upstream of `mixed_column` in the round datapath. It accepts one 128-bit state over a valid/ready handshake and pushes it through four shared S-boxes, one output column per cycle. It then presents the substituted, row-shifted state to the consumer over a second valid/ready handshake. It trades throughput for area: 4 S-box instances instead of 16.

## Interface
- No parameters; width fixed at 128 bits, 4 columns.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `in_valid`  in  1  `data_in` holds a state to accept
- `in_ready`  out  1  block can accept a state this cycle
- `data_in`  in  [0:127]  input state; byte i = bits [8i:8i+7], row i%4, column i/4
- `out_valid`  out  1  `data_out` holds a finished result
- `out_ready`  in  1  consumer takes the result this cycle
- `data_out`  out  [0:127]  result, same byte ordering as `data_in`
- `inv`  in  1  only with `SUB_SHIFT_INV_EN`: 1 selects the inverse transform; sampled on input handshake

## Operation
- FSM states: IDLE, BUSY, DONE. A 2-bit column counter `col` runs 0..3.
- IDLE: `in_ready`=1.
  - On `in_valid`: latch `data_in` into the source register, latch `inv`, clear `col`, go to BUSY.
- BUSY: each cycle computes output column k=`col`.
  - Forward: out byte (row r, col k) = SBOX(src byte (row r, col (k+r) mod 4)), r=0..3.
  - The 4 results are written into column k of the output register, then `col` increments.
  - After k=3 is written, go to DONE.
  - Input handshake is not accepted in BUSY.
- DONE: `out_valid`=1 and `data_out` stays stable.
  - On `out_ready`: go to IDLE.
  - `out_valid` must not drop without `out_ready`.
- Column index arithmetic is 2-bit and wraps mod 4.
- The S-box is a combinational 256-entry FIPS-197 table. It is instantiated 4×, and 8× with INV.
- `in_valid` in BUSY/DONE is ignored and the state is not captured; the upstream holds it until `in_ready`.
- `out_ready` outside DONE has no effect.

## Timing
- Reset values: state IDLE, `col`=0, `out_valid`=0, `data_out`=0, source register 0.
  - `in_ready`=1 on the first cycle after reset deasserts.
- Reset mid-BUSY or in DONE aborts the operation: the partial or complete result is discarded, no `out_valid` pulse, and the registers are cleared as above.
- Input handshake at edge N. Columns 0..3 are written at edges N+1..N+4. `out_valid`=1 from the cycle after edge N+4.
- Output handshake at edge M gives IDLE from M+1, so `in_ready`=1 in cycle M+1.
- Minimum issue interval is 6 cycles, with `out_ready` tied high.
- `data_out` changes only during BUSY writes and reset. Columns not yet written hold the previous result until overwritten.

## Configuration
- `SUB_SHIFT_INV_EN` defined:
  - Adds the `inv` port and 4 InvSBox instances.
  - With `inv`=1: out byte (row r, col k) = INVSBOX(src byte (row r, col (k−r) mod 4)).
  - With `inv`=0: forward behaviour exactly as above.
- Undefined: no `inv` port, no InvSBox logic; forward transform only.

## Test plan
- Reset, then `data_in`=00102030405060708090a0b0c0d0e0f0 with `in_valid` pulse:
  - `out_valid` rises 5 cycles after the handshake.
  - `data_out`=6353e08c0960e104cd70b751bacad0e7.
  - `in_ready`=0 until the output handshake.
- `data_in`=193de3bea0f4e22b9ac68d2ae9f84808 -> `data_out`=d4bf5d30e0b452aeb84111f11e2798e5. Chain into `mixed_column`: column 0 = 046681e5.
- `data_in`=all zeros -> `data_out`=all 63. Hold `out_ready`=0 for 10 cycles:
  - `out_valid` and `data_out` stay stable.
  - A second `in_valid` during DONE is not accepted.
  - Release `out_ready` -> `in_ready`=1 next cycle.
- Assert `reset` 2 cycles after the input handshake:
  - `out_valid` never rises.
  - `data_out`=0 and `in_ready`=1 after reset.
  - A new vector then completes correctly.
- Back-to-back: three vectors with `out_ready` tied high -> handshakes are 6 cycles apart and each result is correct.
- With `SUB_SHIFT_INV_EN`: `inv`=1 and `data_in`=d4bf5d30e0b452aeb84111f11e2798e5 -> `data_out`=193de3bea0f4e22b9ac68d2ae9f84808.
